// File: rtl/proc_seq_pkg.sv
// Shared command/status codes, FSM state type and output decode helpers for proc_seq.
package proc_pkg;

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_START  = 4'd1;
  localparam logic [3:0] CMD_PAUSE  = 4'd2;
  localparam logic [3:0] CMD_RESUME = 4'd3;
  localparam logic [3:0] CMD_ABORT  = 4'd4;
  localparam logic [3:0] CMD_CLEAR  = 4'd5;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RUN      = 4'd1;
  localparam logic [3:0] ST_PAUSED   = 4'd2;
  localparam logic [3:0] ST_DONE     = 4'd3;
  localparam logic [3:0] ST_ABORTED  = 4'd4;
  localparam logic [3:0] ST_ERROR    = 4'd5;
  localparam logic [3:0] ST_CLEARING = 4'd6;

  // StCommit is the acc_en cycle between a finished iteration and the next decision.
  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StIssue,
    StWait,
    StPausePend,
    StCommit,
    StPaused,
    StDrain,
    StDone,
    StAborted,
    StError
  } state_e;

  function automatic logic [3:0] status_of(state_e s);
    logic [3:0] st;
    unique case (s)
      StIdle:                                   st = ST_IDLE;
      StClear:                                  st = ST_CLEARING;
      StIssue, StWait, StPausePend, StCommit,
      StDrain:                                  st = ST_RUN;
      StPaused:                                 st = ST_PAUSED;
      StDone:                                   st = ST_DONE;
      StAborted:                                st = ST_ABORTED;
      StError:                                  st = ST_ERROR;
      default:                                  st = ST_IDLE;
    endcase
    return st;
  endfunction

  function automatic logic busy_of(state_e s);
    return (s == StClear) || (s == StIssue) || (s == StWait) || (s == StPausePend) ||
           (s == StCommit) || (s == StDrain);
  endfunction

endpackage

// File: rtl/proc_seq_cmd_edge.sv
// Host command edge detector: passes a command through only in the cycle it first differs.
module proc_seq_cmd_edge
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       nRESET,
  input  logic [3:0] cmd,
  output logic [3:0] cmd_act
);

  logic [3:0] cmd_prev_q;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cmd_prev_q <= CMD_NOP;
    end else begin
      cmd_prev_q <= cmd;
    end
  end

  assign cmd_act = (cmd != cmd_prev_q) ? cmd : CMD_NOP;

endmodule

// File: rtl/proc_seq.sv
// Run sequencer for the iterative accumulation datapath.
// Define PROC_WDOG_EN to add the per-iteration watchdog and the ERROR state.
module proc_seq
  import proc_pkg::*;
#(
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic [3:0]       cmd,
  input  logic [CNT_W-1:0] niter,
  input  logic             dp_ready,
  input  logic             dp_valid,
  output logic             dp_start,
  output logic             dp_clear,
  output logic             acc_en,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [3:0]       status,
  output logic             busy
);

  localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);

  if (CLR_CYCLES < 1 || WDOG_CYCLES < 2) begin : g_param_check
    $error("proc_seq: CLR_CYCLES must be >= 1 and WDOG_CYCLES >= 2");
  end

  logic [3:0] cmd_act;

  proc_seq_cmd_edge u_cmd_edge (
    .clk     (clk),
    .nRESET  (nRESET),
    .cmd     (cmd),
    .cmd_act (cmd_act)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] niter_lat_q, niter_lat_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic             run_req_q, run_req_d;
  logic             post_pause_q, post_pause_d;
  logic             post_abort_q, post_abort_d;
  logic             start_d, acc_d;
  logic             dp_start_q, dp_clear_q, acc_en_q, busy_q;
  logic [3:0]       status_q;

`ifdef PROC_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d      = state_q;
    niter_lat_d  = niter_lat_q;
    iter_cnt_d   = iter_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    run_req_d    = run_req_q;
    post_pause_d = post_pause_q;
    post_abort_d = post_abort_q;
    start_d      = 1'b0;
    acc_d        = 1'b0;

    unique case (state_q)
      StIdle, StDone, StAborted, StError: begin
        if (cmd_act == CMD_START) begin
          niter_lat_d = niter;
          iter_cnt_d  = '0;
          run_req_d   = 1'b1;
          clr_cnt_d   = '0;
          state_d     = StClear;
        end else if (cmd_act == CMD_CLEAR) begin
          run_req_d = 1'b0;
          clr_cnt_d = '0;
          state_d   = StClear;
        end
      end

      StClear: begin
        if (clr_cnt_q == ClrLast) begin
          if (!run_req_q) begin
            state_d = StIdle;
          end else if (niter_lat_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end else begin
          clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
      end

      // Nothing is in flight yet, so host commands win over launching.
      StIssue: begin
        if (cmd_act == CMD_ABORT) begin
          state_d = StAborted;
        end else if (cmd_act == CMD_PAUSE) begin
          state_d = StPaused;
        end else if (dp_ready) begin
          start_d = 1'b1;
          state_d = StWait;
        end
      end

      // A result arriving with a PAUSE/ABORT edge is committed first; the command is
      // remembered and applied in StCommit.
      StWait, StPausePend: begin
        if (dp_valid) begin
          acc_d = 1'b1;
          if (iter_cnt_q < niter_lat_q) begin
            iter_cnt_d = iter_cnt_q + CNT_W'(1);
          end
          post_pause_d = (state_q == StPausePend) || (cmd_act == CMD_PAUSE);
          post_abort_d = (cmd_act == CMD_ABORT);
          state_d      = StCommit;
        end else if (cmd_act == CMD_ABORT) begin
          state_d = StDrain;
        end else if (cmd_act == CMD_PAUSE) begin
          state_d = StPausePend;
        end
      end

      StCommit: begin
        if (post_abort_q || (cmd_act == CMD_ABORT)) begin
          state_d = StAborted;
        end else if (iter_cnt_q == niter_lat_q) begin
          state_d = StDone;
        end else if (post_pause_q || (cmd_act == CMD_PAUSE)) begin
          state_d = StPaused;
        end else begin
          state_d = StIssue;
        end
      end

      StPaused: begin
        if (cmd_act == CMD_RESUME) begin
          state_d = StIssue;
        end else if (cmd_act == CMD_ABORT) begin
          state_d = StAborted;
        end
      end

      StDrain: begin
        if (dp_valid) begin
          state_d = StAborted;
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef PROC_WDOG_EN
    // One timeout window per iteration; it survives WAIT -> PAUSE_PEND/DRAIN.
    wdog_d = '0;
    if (((state_q == StWait) || (state_q == StPausePend) || (state_q == StDrain)) &&
        !dp_valid) begin
      if (wdog_q == WdogLast) begin
        state_d = StError;
      end else begin
        wdog_d = wdog_q + WdogW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= StIdle;
      niter_lat_q  <= '0;
      iter_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      run_req_q    <= 1'b0;
      post_pause_q <= 1'b0;
      post_abort_q <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_clear_q   <= 1'b0;
      acc_en_q     <= 1'b0;
      status_q     <= ST_IDLE;
      busy_q       <= 1'b0;
`ifdef PROC_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      niter_lat_q  <= niter_lat_d;
      iter_cnt_q   <= iter_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      run_req_q    <= run_req_d;
      post_pause_q <= post_pause_d;
      post_abort_q <= post_abort_d;
      dp_start_q   <= start_d;
      dp_clear_q   <= (state_d == StClear);
      acc_en_q     <= acc_d;
      status_q     <= status_of(state_d);
      busy_q       <= busy_of(state_d);
`ifdef PROC_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign dp_start = dp_start_q;
  assign dp_clear = dp_clear_q;
  assign acc_en   = acc_en_q;
  assign iter_cnt = iter_cnt_q;
  assign status   = status_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_proc_seq.sv
// Self-checking bench for proc_seq: randomized datapath responder plus run-level expectations.
module tb_proc_seq;

  localparam int unsigned ClrCycles  = 4;
  localparam int unsigned CntW       = 32;
  localparam int unsigned WdogCycles = 16;

  localparam logic [3:0] C_NOP = 4'd0, C_START = 4'd1, C_PAUSE = 4'd2;
  localparam logic [3:0] C_RESUME = 4'd3, C_ABORT = 4'd4, C_CLEAR = 4'd5;
  localparam logic [3:0] S_IDLE = 4'd0, S_RUN = 4'd1, S_PAUSED = 4'd2, S_DONE = 4'd3;
  localparam logic [3:0] S_ABORTED = 4'd4, S_ERROR = 4'd5, S_CLEARING = 4'd6;

  logic            clk, nRESET;
  logic [3:0]      cmd;
  logic [CntW-1:0] niter;
  logic            dp_ready, dp_valid;
  logic            dp_start, dp_clear, acc_en, busy;
  logic [CntW-1:0] iter_cnt;
  logic [3:0]      status;

  int tests = 0;
  int fails = 0;

  // Datapath responder / monitor state (written only by the monitor process).
  int cyc_no, pend, n_start, n_acc, n_clr;
  int start_q[$], valid_q[$], acc_q[$];
  // Knobs written only by the main process.
  int lat_min = 2, lat_max = 2;
  bit suppress = 1'b0, rand_ready = 1'b0, flush = 1'b0;

  proc_seq #(
    .CLR_CYCLES  (ClrCycles),
    .CNT_W       (CntW),
    .WDOG_CYCLES (WdogCycles)
  ) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .cmd      (cmd),
    .niter    (niter),
    .dp_ready (dp_ready),
    .dp_valid (dp_valid),
    .dp_start (dp_start),
    .dp_clear (dp_clear),
    .acc_en   (acc_en),
    .iter_cnt (iter_cnt),
    .status   (status),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model: dp_valid a random latency after each dp_start; logs activity per cycle.
  initial begin
    dp_valid = 1'b0; dp_ready = 1'b1;
    pend = 0; cyc_no = 0; n_start = 0; n_acc = 0; n_clr = 0;
    forever begin
      @(negedge clk);
      cyc_no++;
      dp_valid = 1'b0;
      dp_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (flush) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !suppress) begin
          dp_valid = 1'b1;
          valid_q.push_back(cyc_no);
        end
      end
      if (dp_start) begin
        n_start++;
        start_q.push_back(cyc_no);
        pend = int'($urandom_range(lat_max, lat_min));
      end
      if (acc_en) begin
        n_acc++;
        acc_q.push_back(cyc_no);
      end
      if (dp_clear) n_clr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_run(input int n);
    niter = CntW'(n);
    cmd = C_NOP;
    tick(1);
    cmd = C_START;
    tick(1);
  endtask

  task automatic wait_status(input logic [3:0] s, input int budget, output bit ok);
    int k = 0;
    while (status !== s && k < budget) begin
      tick(1);
      k++;
    end
    ok = (status === s);
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_start < target && k < budget) begin
      tick(1);
      k++;
    end
    ok = (n_start >= target);
  endtask

  task automatic test_reset();
    nRESET = 1'b0; cmd = C_NOP; niter = '0;
    tick(3);
    tests++; if (status !== S_IDLE) begin fails++; $display("FAIL reset_status: got %0d, want %0d", status, S_IDLE); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, want 0", busy); end
    tests++; if ({dp_start, dp_clear, acc_en} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b, want 000", {dp_start, dp_clear, acc_en}); end
    tests++; if (iter_cnt !== '0) begin fails++; $display("FAIL reset_iter_cnt: got %0d, want 0", iter_cnt); end
    nRESET = 1'b1;
    tick(3);
    tests++; if (status !== S_IDLE || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got status %0d busy %b, want 0/0", status, busy); end
  endtask

  task automatic test_run();
    int n, b_start, b_acc, b_clr, b_sq, b_vq, b_aq;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 3 : int'($urandom_range(6, 1));
      lat_min = (k == 0) ? 5 : 1;
      lat_max = (k == 0) ? 5 : int'($urandom_range(6, 1));
      b_start = n_start; b_acc = n_acc; b_clr = n_clr;
      b_sq = start_q.size(); b_vq = valid_q.size(); b_aq = acc_q.size();
      start_run(n);
      wait_status(S_DONE, 60 + n * 16, ok);
      tests++; if (!ok) begin fails++; $display("FAIL run_done[%0d]: status %0d, want %0d", k, status, S_DONE); end
      tests++; if (n_clr - b_clr != ClrCycles) begin fails++; $display("FAIL run_clear_len[%0d]: got %0d, want %0d", k, n_clr - b_clr, ClrCycles); end
      tests++; if (n_start - b_start != n) begin fails++; $display("FAIL run_starts[%0d]: got %0d, want %0d", k, n_start - b_start, n); end
      tests++; if (n_acc - b_acc != n) begin fails++; $display("FAIL run_accs[%0d]: got %0d, want %0d", k, n_acc - b_acc, n); end
      tests++; if (iter_cnt !== CntW'(n)) begin fails++; $display("FAIL run_iter_cnt[%0d]: got %0d, want %0d", k, iter_cnt, n); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL run_busy[%0d]: got %b, want 0", k, busy); end
      for (int i = 0; i < n && b_vq + i < valid_q.size() && b_aq + i < acc_q.size(); i++) begin
        tests++; if (acc_q[b_aq + i] != valid_q[b_vq + i] + 1) begin fails++; $display("FAIL run_acc_timing[%0d.%0d]: acc cycle %0d, want %0d", k, i, acc_q[b_aq + i], valid_q[b_vq + i] + 1); end
        if (b_sq + i + 1 < start_q.size()) begin
          tests++; if (start_q[b_sq + i + 1] != valid_q[b_vq + i] + 3) begin fails++; $display("FAIL run_turnaround[%0d.%0d]: start cycle %0d, want %0d", k, i, start_q[b_sq + i + 1], valid_q[b_vq + i] + 3); end
        end
      end
    end
  endtask

  task automatic test_zero_iter();
    int b_start = n_start, b_clr = n_clr;
    bit ok;
    start_run(0);
    wait_status(S_DONE, 20, ok);
    tick(4);
    tests++; if (!ok || status !== S_DONE) begin fails++; $display("FAIL zero_done: status %0d, want %0d", status, S_DONE); end
    tests++; if (n_start != b_start) begin fails++; $display("FAIL zero_no_start: got %0d starts, want 0", n_start - b_start); end
    tests++; if (n_clr - b_clr != ClrCycles) begin fails++; $display("FAIL zero_clear_len: got %0d, want %0d", n_clr - b_clr, ClrCycles); end
    tests++; if (iter_cnt !== '0) begin fails++; $display("FAIL zero_iter_cnt: got %0d, want 0", iter_cnt); end
  endtask

  task automatic test_pause_resume();
    int b_start = n_start, b_acc = n_acc, frozen;
    bit ok;
    lat_min = int'($urandom_range(6, 3)); lat_max = lat_min;
    start_run(10);
    wait_starts(b_start + 4, 200, ok);
    cmd = C_PAUSE;
    wait_status(S_PAUSED, 40, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pause_status: got %0d, want %0d", status, S_PAUSED); end
    tests++; if (iter_cnt !== CntW'(4) || n_acc - b_acc != 4) begin fails++; $display("FAIL pause_commit: iter_cnt %0d acc %0d, want 4/4", iter_cnt, n_acc - b_acc); end
    frozen = n_start;
    tick(12);
    tests++; if (n_start != frozen || status !== S_PAUSED || busy !== 1'b0) begin fails++; $display("FAIL paused_idle: starts +%0d status %0d busy %b, want +0/2/0", n_start - frozen, status, busy); end
    cmd = C_RESUME;
    wait_status(S_DONE, 200, ok);
    tests++; if (!ok || iter_cnt !== CntW'(10)) begin fails++; $display("FAIL resume_done: status %0d iter_cnt %0d, want 3/10", status, iter_cnt); end
    tests++; if (n_start - b_start != 10 || n_acc - b_acc != 10) begin fails++; $display("FAIL resume_counts: starts %0d accs %0d, want 10/10", n_start - b_start, n_acc - b_acc); end
  endtask

  task automatic test_abort_drain();
    int b_start = n_start, b_acc = n_acc;
    bit ok;
    lat_min = 4; lat_max = 4;
    start_run(8);
    wait_starts(b_start + 2, 100, ok);
    cmd = C_ABORT;  // dp_valid lands 3 cycles after the edge is sampled
    wait_status(S_ABORTED, 40, ok);
    tick(6);
    tests++; if (!ok || status !== S_ABORTED) begin fails++; $display("FAIL abort_status: got %0d, want %0d", status, S_ABORTED); end
    tests++; if (n_acc - b_acc != 1 || iter_cnt !== CntW'(1)) begin fails++; $display("FAIL abort_discard: acc %0d iter_cnt %0d, want 1/1", n_acc - b_acc, iter_cnt); end
    tests++; if (busy !== 1'b0 || n_start - b_start != 2) begin fails++; $display("FAIL abort_quiet: busy %b starts %0d, want 0/2", busy, n_start - b_start); end
  endtask

  task automatic test_abort_with_valid();
    int b_start = n_start, b_acc = n_acc, lat;
    bit ok;
    lat = int'($urandom_range(6, 3));
    lat_min = lat; lat_max = lat;
    start_run(6);
    wait_starts(b_start + 2, 100, ok);
    tick(lat - 1);
    cmd = C_ABORT;  // same cycle as the 2nd dp_valid
    wait_status(S_ABORTED, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL abort_valid_status: got %0d, want %0d", status, S_ABORTED); end
    tests++; if (n_acc - b_acc != 2 || iter_cnt !== CntW'(2)) begin fails++; $display("FAIL abort_valid_commit: acc %0d iter_cnt %0d, want 2/2", n_acc - b_acc, iter_cnt); end
  endtask

  task automatic test_hold_restart();
    int b_start;
    bit ok;
    lat_min = 1; lat_max = 3;
    start_run(2);
    wait_status(S_DONE, 80, ok);
    b_start = n_start;
    tick(20);
    tests++; if (n_start != b_start || status !== S_DONE || iter_cnt !== CntW'(2)) begin fails++; $display("FAIL hold_no_restart: starts +%0d status %0d iter_cnt %0d, want +0/3/2", n_start - b_start, status, iter_cnt); end
    start_run(3);
    tests++; if (status !== S_CLEARING || dp_clear !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL restart_clear: status %0d dp_clear %b busy %b, want 6/1/1", status, dp_clear, busy); end
    tests++; if (iter_cnt !== '0) begin fails++; $display("FAIL restart_iter_cnt: got %0d, want 0", iter_cnt); end
    wait_status(S_DONE, 80, ok);
    tests++; if (!ok || iter_cnt !== CntW'(3)) begin fails++; $display("FAIL restart_done: status %0d iter_cnt %0d, want 3/3", status, iter_cnt); end
  endtask

  task automatic test_random_ready();
    int n, b_start = n_start, b_acc = n_acc;
    bit ok;
    n = int'($urandom_range(8, 2));
    lat_min = 1; lat_max = 5; rand_ready = 1'b1;
    start_run(n);
    wait_status(S_DONE, 60 + n * 40, ok);
    rand_ready = 1'b0;
    tests++; if (!ok || iter_cnt !== CntW'(n)) begin fails++; $display("FAIL rnd_ready_done: status %0d iter_cnt %0d, want 3/%0d", status, iter_cnt, n); end
    tests++; if (n_start - b_start != n || n_acc - b_acc != n) begin fails++; $display("FAIL rnd_ready_counts: starts %0d accs %0d, want %0d", n_start - b_start, n_acc - b_acc, n); end
  endtask

`ifdef PROC_WDOG_EN
  task automatic test_wdog();
    int b_start = n_start, b_acc = n_acc;
    bit ok;
    suppress = 1'b1; lat_min = 2; lat_max = 2;
    start_run(5);
    wait_starts(b_start + 1, 40, ok);
    tick(14);
    tests++; if (status !== S_RUN) begin fails++; $display("FAIL wdog_early: status %0d, want %0d", status, S_RUN); end
    tick(1);
    tests++; if (status !== S_ERROR || busy !== 1'b0) begin fails++; $display("FAIL wdog_error: status %0d busy %b, want 5/0", status, busy); end
    tests++; if (n_acc != b_acc) begin fails++; $display("FAIL wdog_no_acc: got %0d, want 0", n_acc - b_acc); end
    flush = 1'b1;
    cmd = C_CLEAR;
    tick(2);
    flush = 1'b0; suppress = 1'b0;
    wait_status(S_IDLE, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wdog_clear_exit: status %0d, want %0d", status, S_IDLE); end
  endtask
`endif

  task automatic test_async_reset();
    int b_start = n_start;
    bit ok;
    lat_min = 8; lat_max = 8;
    start_run(5);
    wait_starts(b_start + 1, 40, ok);
    tick(1);
    nRESET = 1'b0;
    #1;
    tests++; if ({dp_start, dp_clear, acc_en, busy} !== 4'b0000 || status !== S_IDLE) begin fails++; $display("FAIL async_reset_out: pulses/busy %b status %0d, want 0000/0", {dp_start, dp_clear, acc_en, busy}, status); end
    tests++; if (iter_cnt !== '0) begin fails++; $display("FAIL async_reset_cnt: got %0d, want 0", iter_cnt); end
    flush = 1'b1;
    cmd = C_NOP;
    tick(3);
    flush = 1'b0;
    nRESET = 1'b1;
    tick(6);
    tests++; if (status !== S_IDLE || busy !== 1'b0) begin fails++; $display("FAIL async_reset_idle: status %0d busy %b, want 0/0", status, busy); end
  endtask

  initial begin
    nRESET = 1'b0; cmd = C_NOP; niter = '0;
    test_reset();
    test_run();
    test_zero_iter();
    test_pause_resume();
    test_abort_drain();
    test_abort_with_valid();
    test_hold_restart();
    test_random_ready();
`ifdef PROC_WDOG_EN
    test_wdog();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
